// File: rtl/ram2_port_arbiter.sv
// Read-port arbiter sharing one simple dual-port RAM between IF and LS. LS has priority, and IF starvation is bounded.
// Optional macro RAM2_ARB_BYPASS_EN forwards same-cycle write data to a colliding read.
module ram2_port_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int IF_MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT = 4'(IF_MAX_WAIT);

    logic [3:0]            starve_cnt;
    owner_t                owner;
    logic                  ls_wr;
    logic                  ls_rd;
    logic                  if_rd;
    logic                  grant_if;
    logic                  grant_ls;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] ls_rdata_q;

    assign ls_wr    = ls_req && ls_we && !reset;
    assign ls_rd    = ls_req && !ls_we && !reset;
    assign if_rd    = if_req && !reset;
    // IF only beats a competing LS read once it has lost IF_MAX_WAIT times in a row.
    assign grant_if = if_rd && (!ls_rd || (starve_cnt == MAX_WAIT));
    assign grant_ls = ls_rd && !grant_if;

    assign if_gnt            = grant_if;
    assign ls_gnt            = grant_ls || ls_wr;
    assign ram_write         = ls_wr;
    assign ram_write_address = ls_addr;
    assign ram_din           = ls_wdata;
    assign ram_read_address  = grant_ls ? ls_addr : if_addr;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
        if (reset) begin
            starve_cnt <= 4'd0;
            owner      <= OWN_NONE;
        end else begin
            if (!if_req || grant_if)
                starve_cnt <= 4'd0;
            else if (ls_rd && starve_cnt != MAX_WAIT)
                starve_cnt <= starve_cnt + 4'd1;

            if (grant_if)
                owner <= OWN_IF;
            else if (grant_ls)
                owner <= OWN_LS;
            else
                owner <= OWN_NONE;
        end
    end

    // A response whose grant preceded a reset cycle is dropped.
    assign if_rvalid = (owner == OWN_IF) && !reset;
    assign ls_rvalid = (owner == OWN_LS) && !reset;
    assign if_rdata  = if_rvalid ? rsp_data : if_rdata_q;
    assign ls_rdata  = ls_rvalid ? rsp_data : ls_rdata_q;

    // NOTE: the held read-data registers are pure datapath qualified by rvalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (if_rvalid) if_rdata_q <= rsp_data;
        if (ls_rvalid) ls_rdata_q <= rsp_data;
    end

`ifdef RAM2_ARB_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;

    always_ff @(posedge clk) begin
        if (reset)
            byp_hit <= 1'b0;
        else
            byp_hit <= (grant_if || grant_ls) && ls_wr && (ram_read_address == ls_addr);
    end

    always_ff @(posedge clk) begin
        byp_data <= ls_wdata;
    end

    assign rsp_data = byp_hit ? byp_data : ram_dout;
`else
    assign rsp_data = ram_dout;
`endif

endmodule

// File: tb/tb_ram2_port_arbiter.sv
// Scoreboard bench for ram2_port_arbiter with a behavioural RAM. Read expectations are queued at grant and popped at rvalid.
module tb_ram2_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int MW = 3;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic [AW-1:0] ram_read_address;
    logic [AW-1:0] ram_write_address;
    logic          ram_write;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IF_MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, old data on read-during-write.
    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] shadow [2**AW];

    always @(posedge clk) begin
        if (ram_write) mem[ram_write_address] <= ram_din;
        ram_dout <= mem[ram_read_address];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] if_q[$];
    logic [DW-1:0] ls_q[$];
    logic [3:0]    st = 4'd0;
    logic          prev_if = 1'b0, prev_ls = 1'b0;
    logic          have_if = 1'b0, have_ls = 1'b0;
    logic [DW-1:0] last_if, last_ls, ed;
    logic          e_if, e_ls, e_wr, lrd;
    logic          if_hold = 1'b0, ls_hold = 1'b0;

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input logic wr);
`ifdef RAM2_ARB_BYPASS_EN
        if (wr && ls_addr == a) return ls_wdata;
`endif
        return shadow[a];
    endfunction

    always @(negedge clk) begin
        // Responses for grants seen last cycle
        check("if_rvalid", 32'(if_rvalid), 32'(prev_if && !reset));
        if (prev_if) begin
            if (if_q.size() == 0) check("if_q_underflow", 32'd1, 32'd0);
            else begin
                ed = if_q.pop_front();
                if (!reset) begin
                    check("if_rdata", 32'(if_rdata), 32'(ed));
                    last_if = ed; have_if = 1'b1;
                end
            end
        end
        if (!(prev_if && !reset) && have_if) check("if_rdata_hold", 32'(if_rdata), 32'(last_if));

        check("ls_rvalid", 32'(ls_rvalid), 32'(prev_ls && !reset));
        if (prev_ls) begin
            if (ls_q.size() == 0) check("ls_q_underflow", 32'd1, 32'd0);
            else begin
                ed = ls_q.pop_front();
                if (!reset) begin
                    check("ls_rdata", 32'(ls_rdata), 32'(ed));
                    last_ls = ed; have_ls = 1'b1;
                end
            end
        end
        if (!(prev_ls && !reset) && have_ls) check("ls_rdata_hold", 32'(ls_rdata), 32'(last_ls));

        // Grants for this cycle
        lrd  = ls_req && !ls_we && !reset;
        e_wr = ls_req && ls_we && !reset;
        e_if = if_req && !reset && (!lrd || st == 4'(MW));
        e_ls = lrd && !e_if;
        check("if_gnt", 32'(if_gnt), 32'(e_if));
        check("ls_gnt", 32'(ls_gnt), 32'(e_ls || e_wr));
        check("ram_write", 32'(ram_write), 32'(e_wr));
        if (e_wr) begin
            check("ram_write_address", 32'(ram_write_address), 32'(ls_addr));
            check("ram_din", 32'(ram_din), 32'(ls_wdata));
        end
        if (e_if) check("ram_read_address_if", 32'(ram_read_address), 32'(if_addr));
        if (e_ls) check("ram_read_address_ls", 32'(ram_read_address), 32'(ls_addr));

        assert (!(!reset && if_hold && !if_req)) else $error("if_req dropped before grant");
        assert (!(!reset && ls_hold && !ls_req)) else $error("ls_req dropped before grant");

        if (e_if) if_q.push_back(exp_read(if_addr, e_wr));
        if (e_ls) ls_q.push_back(exp_read(ls_addr, e_wr));
        if (e_wr) shadow[ls_addr] = ls_wdata;

        if (reset || !if_req || e_if) st = 4'd0;
        else if (lrd && st != 4'(MW)) st = st + 4'd1;

        if_hold = if_req && !e_if && !reset;
        ls_hold = ls_req && !(e_ls || e_wr) && !reset;
        prev_if = e_if;
        prev_ls = e_ls;
    end

    task automatic drive(input logic rst, input logic ir, input logic [AW-1:0] ia,
                         input logic lr, input logic lw, input logic [AW-1:0] la,
                         input logic [DW-1:0] ld);
        @(posedge clk);
        #1;
        reset = rst; if_req = ir; if_addr = ia;
        ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
    endtask

    int            if_wins;
    logic          ip, lp, ir, lr, lw;
    logic [AW-1:0] ia, la;
    logic [DW-1:0] ld;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem[i]    = 16'(i) ^ 16'hC300;
            shadow[i] = 16'(i) ^ 16'hC300;
        end
        mem[5] = 16'h00A5; shadow[5] = 16'h00A5;
        reset = 1'b1; if_req = 1'b1; if_addr = 9'd5;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'd2; ls_wdata = '0;

        // Reset held with both requesting, then IF alone reads address 5
        drive(1'b1, 1'b1, 9'd5, 1'b1, 1'b0, 9'd2, 16'h0);
        drive(1'b0, 1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);

        // Continuous contention: LS,LS,LS,IF repeating
        if_wins = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b1, 9'd1, 1'b1, 1'b0, 9'd2, 16'h0);
            @(negedge clk);
            if (if_gnt) if_wins++;
        end
        check("contention_if_wins", 32'(if_wins), 32'd3);
        drive(1'b0, 1'b1, 9'd1, 1'b1, 1'b0, 9'd2, 16'h0);
        drive(1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);

        // Read-during-write on address 7, then a clean read of 7
        drive(1'b0, 1'b1, 9'd7, 1'b1, 1'b1, 9'd7, 16'h1234);
        drive(1'b0, 1'b1, 9'd7, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);

        // LS read granted, reset the following cycle drops the response
        drive(1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 9'd9, 16'h0);
        drive(1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);

        // Write 3 then read 3 back-to-back
        drive(1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 9'd3, 16'hBEEF);
        drive(1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 9'd3, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);

        // Mixed traffic on a small address window, requests held until granted
        ip = 1'b0; lp = 1'b0;
        ir = 1'b0; ia = '0; lr = 1'b0; lw = 1'b0; la = '0; ld = '0;
        for (int c = 0; c < 80; c++) begin
            if (!ip) begin
                ir = 1'($urandom_range(0, 1));
                ia = 9'($urandom_range(0, 7));
            end
            if (!lp) begin
                lr = 1'($urandom_range(0, 1));
                lw = 1'($urandom_range(0, 1));
                la = 9'($urandom_range(0, 7));
                ld = 16'($urandom);
            end
            drive(1'b0, ir, ia, lr, lw, la, ld);
            @(negedge clk);
            ip = ir && !if_gnt;
            lp = lr && !ls_gnt;
        end
        // Let any held request finish before going idle
        for (int c = 0; c < 8 && (ip || lp); c++) begin
            drive(1'b0, ip, ia, lp, lw, la, ld);
            @(negedge clk);
            ip = ip && !if_gnt;
            lp = lp && !ls_gnt;
        end
        check("drain_bound", 32'(ip || lp), 32'd0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
        drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 16'h0);
        @(negedge clk);
        #1;

        check("if_q_empty", 32'(if_q.size()), 32'd0);
        check("ls_q_empty", 32'(ls_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram2_port_arbiter.md
Name: ram2_port_arbiter

Overview:
Shares one simple dual-port synchronous RAM between two requesters: the instruction-fetch (IF) stage and the load/store (LS) stage of the pipelined CPU. The RAM has one read port and one write port, with 1-cycle registered read and old-data read-during-write. Writes go straight to the write port. Read-port contention uses LS-priority arbitration with a bounded IF starvation limit. Read data returns one cycle after grant, steered back to the requester that won.

Parameters:
DATA_WIDTH, 16, RAM word width
ADDR_WIDTH, 9, RAM address width
IF_MAX_WAIT, 3, max consecutive contended cycles IF may lose before it is forced to win (1..15)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  ADDR_WIDTH  IF read address
if_gnt  out  1  IF read accepted this cycle (combinational)
if_rvalid  out  1  IF read data valid (cycle after if_gnt)
if_rdata  out  DATA_WIDTH  IF read data
ls_req  in  1  LS request; held with ls_we/ls_addr/ls_wdata until ls_gnt
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_WIDTH  LS address
ls_wdata  in  DATA_WIDTH  LS write data
ls_gnt  out  1  LS request accepted this cycle (combinational)
ls_rvalid  out  1  LS read data valid (cycle after read grant)
ls_rdata  out  DATA_WIDTH  LS read data
ram_read_address  out  ADDR_WIDTH  to RAM read_address
ram_write_address  out  ADDR_WIDTH  to RAM write_address
ram_write  out  1  to RAM write
ram_din  out  DATA_WIDTH  to RAM din
ram_dout  in  DATA_WIDTH  from RAM dout

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset (reset=1 at posedge): if_rvalid=0, ls_rvalid=0, starvation counter=0, response-owner register=NONE. While reset=1, combinationally: if_gnt=0, ls_gnt=0, ram_write=0.
- LS write (ls_req & ls_we): ls_gnt=1 the same cycle, always. Drives ram_write=1, ram_write_address=ls_addr, ram_din=ls_wdata. Never blocks IF.
- Read-port arbitration each cycle:
  - only IF reading: IF wins.
  - only LS reading: LS wins.
  - both (if_req & ls_req & !ls_we): LS wins unless starve_cnt == IF_MAX_WAIT, in which case IF wins.
- starve_cnt: increments when IF loses a contended cycle. Resets to 0 whenever IF is granted or if_req=0. Saturates at IF_MAX_WAIT.
- ram_read_address = winner's address. When there is no read winner, it is held at if_addr (don't-care for function).
- Owner register (2-bit state: NONE/IF/LS) captures the winner at posedge. If no read was granted, it captures NONE.
- Response: owner=IF → if_rvalid=1, if_rdata=ram_dout. Owner=LS → ls_rvalid=1, ls_rdata=ram_dout. rdata of the non-owner holds its last value.
- Latency: exactly 1 cycle from gnt to rvalid. Throughput: one read per cycle.
- Read-during-write on the same address in the same cycle: the RAM returns OLD data. The arbiter passes it through unchanged unless the optional feature is enabled.
- Write in cycle N, read of the same address granted in N+1: returns new data; no action needed.
- Reset asserted the cycle after a grant: rvalid is 0 the cycle after reset. The in-flight response is dropped.
- Requester dropping req before gnt: illegal; behaviour undefined, flagged by bench assertion.

Optional Feature:
RAM2_ARB_BYPASS_EN.
- Defined: registers a match flag when a granted read address equals ram_write_address with ram_write=1 in the same cycle, together with the write data. The next cycle, the responding rdata = registered ls_wdata instead of ram_dout, so the read sees the new data.
- Undefined: no comparator or registers. rdata is always ram_dout, giving old-data semantics.

Test Plan:
- Reset hold 2 cycles with if_req=1, ls_req=1 → if_gnt=ls_gnt=0, ram_write=0, both rvalid=0. Release → IF gnt next cycle if LS idle.
- RAM preloaded mem[5]=16'h00A5; IF reads 5 → if_gnt cycle N, if_rvalid=1 and if_rdata=16'h00A5 at N+1, ls_rvalid=0.
- IF and LS read continuously (addr 1 and 2, IF_MAX_WAIT=3) → LS,LS,LS,IF grant pattern repeats; starve_cnt never exceeds 3.
- LS write addr 7 = 16'h1234 while IF reads 7 in the same cycle → both gnt. if_rdata = old mem[7] without RAM2_ARB_BYPASS_EN, 16'h1234 with it. IF read of 7 the next cycle → 16'h1234 either way.
- LS read granted at cycle N, reset=1 at N+1 → ls_rvalid=0 at N+1 and N+2. Owner=NONE after reset.
- Back-to-back: LS write 3=16'hBEEF, then LS read 3 → ls_rvalid with 16'hBEEF two cycles after the write.
